// File: rtl/mips_exec_datapath.sv
// Registered execute/memory slice: ALU control decode, 32-bit ALU and big-endian byte-lane load/store logic.
// Optional macro OVERFLOW_TRAP_EN enables signed-overflow flagging for ADD, SUB and ADDI.
module mips_exec_datapath (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [31:0] rt_val,
  input  logic [31:0] readdata_eb,
  input  logic [1:0]  ld_lsb,
  output logic        out_valid,
  output logic [31:0] alu_out,
  output logic [3:0]  byteenable,
  output logic [31:0] store_data,
  output logic [31:0] load_word,
  output logic        illegal,
  output logic        overflow
);

  // ADDT/SUBT are the trapping forms; they compute exactly like ADD/SUB.
  typedef enum logic [3:0] {
    ALU_ZERO, ALU_ADD, ALU_ADDT, ALU_SUB, ALU_SUBT, ALU_AND, ALU_OR, ALU_XOR,
    ALU_NOR, ALU_SLT, ALU_SLTU, ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI, ALU_PASSA
  } alu_op_e;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LBU, MEM_LH, MEM_LHU, MEM_LW, MEM_LWL, MEM_LWR,
    MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  alu_op_e     alu_op;
  mem_op_e     mem_op;
  logic        dec_ill;

  logic [31:0] sum;
  logic [31:0] diff;
  logic [4:0]  sh;
  logic [31:0] alu_res;

  logic [1:0]  e;
  logic [3:0]  be_res;
  logic [31:0] sd_res;
  logic [31:0] ld_res;
  logic        misalign;
  logic        ovf_res;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [1:0]  ld_inv;
  logic [4:0]  lsh;
  logic [4:0]  rsh;

  logic        out_valid_d, out_valid_q;
  logic [31:0] alu_out_d, alu_out_q;
  logic [3:0]  byteenable_d, byteenable_q;
  logic [31:0] store_data_d, store_data_q;
  logic [31:0] load_word_d, load_word_q;
  logic        illegal_d, illegal_q;
  logic        overflow_d, overflow_q;

  always_comb begin
    alu_op  = ALU_ZERO;
    mem_op  = MEM_NONE;
    dec_ill = 1'b0;
    if (opcode == 6'b000000) begin
      unique case (funct)
        6'b000000, 6'b000100: alu_op = ALU_SLL;
        6'b000010, 6'b000110: alu_op = ALU_SRL;
        6'b000011, 6'b000111: alu_op = ALU_SRA;
        6'b001000:            alu_op = ALU_PASSA;
        6'b100000:            alu_op = ALU_ADDT;
        6'b100001:            alu_op = ALU_ADD;
        6'b100010:            alu_op = ALU_SUBT;
        6'b100011:            alu_op = ALU_SUB;
        6'b100100:            alu_op = ALU_AND;
        6'b100101:            alu_op = ALU_OR;
        6'b100110:            alu_op = ALU_XOR;
        6'b100111:            alu_op = ALU_NOR;
        6'b101010:            alu_op = ALU_SLT;
        6'b101011:            alu_op = ALU_SLTU;
        default:              dec_ill = 1'b1;
      endcase
    end else begin
      unique case (opcode)
        6'b000001, 6'b000010, 6'b000011, 6'b000100,
        6'b000101, 6'b000110, 6'b000111: alu_op = ALU_ADD;
        6'b001000: alu_op = ALU_ADDT;
        6'b001001: alu_op = ALU_ADD;
        6'b001010: alu_op = ALU_SLT;
        6'b001011: alu_op = ALU_SLTU;
        6'b001100: alu_op = ALU_AND;
        6'b001101: alu_op = ALU_OR;
        6'b001110: alu_op = ALU_XOR;
        6'b001111: alu_op = ALU_LUI;
        6'b100000: begin alu_op = ALU_ADD; mem_op = MEM_LB;  end
        6'b100001: begin alu_op = ALU_ADD; mem_op = MEM_LH;  end
        6'b100010: begin alu_op = ALU_ADD; mem_op = MEM_LWL; end
        6'b100011: begin alu_op = ALU_ADD; mem_op = MEM_LW;  end
        6'b100100: begin alu_op = ALU_ADD; mem_op = MEM_LBU; end
        6'b100101: begin alu_op = ALU_ADD; mem_op = MEM_LHU; end
        6'b100110: begin alu_op = ALU_ADD; mem_op = MEM_LWR; end
        6'b101000: begin alu_op = ALU_ADD; mem_op = MEM_SB;  end
        6'b101001: begin alu_op = ALU_ADD; mem_op = MEM_SH;  end
        6'b101011: begin alu_op = ALU_ADD; mem_op = MEM_SW;  end
        default:   dec_ill = 1'b1;
      endcase
    end
  end

  always_comb begin
    sum  = a + b;
    diff = a - b;
    sh   = a[4:0];
    unique case (alu_op)
      ALU_ADD, ALU_ADDT: alu_res = sum;
      ALU_SUB, ALU_SUBT: alu_res = diff;
      ALU_AND:           alu_res = a & b;
      ALU_OR:            alu_res = a | b;
      ALU_XOR:           alu_res = a ^ b;
      ALU_NOR:           alu_res = ~(a | b);
      ALU_SLT:           alu_res = {31'b0, $signed(a) < $signed(b)};
      ALU_SLTU:          alu_res = {31'b0, a < b};
      ALU_SLL:           alu_res = b << sh;
      ALU_SRL:           alu_res = b >> sh;
      ALU_SRA:           alu_res = $signed(b) >>> sh;
      ALU_LUI:           alu_res = {b[15:0], 16'h0000};
      ALU_PASSA:         alu_res = a;
      default:           alu_res = '0;
    endcase
  end

  always_comb begin
    ovf_res = 1'b0;
`ifdef OVERFLOW_TRAP_EN
    if (alu_op == ALU_ADDT)
      ovf_res = (a[31] == b[31]) && (sum[31] != a[31]);
    else if (alu_op == ALU_SUBT)
      ovf_res = (a[31] != b[31]) && (diff[31] != a[31]);
`endif
  end

  // Load lanes come from ld_lsb (the returning load); enables/store data from the current EA.
  always_comb begin
    e        = sum[1:0];
    be_res   = '0;
    sd_res   = '0;
    ld_res   = '0;
    misalign = 1'b0;
    unique case (ld_lsb)
      2'd0:    ld_byte = readdata_eb[31:24];
      2'd1:    ld_byte = readdata_eb[23:16];
      2'd2:    ld_byte = readdata_eb[15:8];
      default: ld_byte = readdata_eb[7:0];
    endcase
    ld_half = ld_lsb[1] ? readdata_eb[15:0] : readdata_eb[31:16];
    ld_inv  = 2'd3 - ld_lsb;
    lsh     = {ld_lsb, 3'b000};
    rsh     = {ld_inv, 3'b000};
    unique case (mem_op)
      MEM_LB, MEM_LBU, MEM_SB: begin
        be_res = 4'b0001 << e;
        sd_res = {4{rt_val[7:0]}};
      end
      MEM_LH, MEM_LHU, MEM_SH: begin
        be_res   = e[1] ? 4'b1100 : 4'b0011;
        sd_res   = {2{rt_val[15:0]}};
        misalign = e[0];
      end
      MEM_LW, MEM_SW: begin
        be_res   = 4'b1111;
        sd_res   = rt_val;
        misalign = |e;
      end
      MEM_LWL: begin
        be_res = 4'b1111 << e;
        sd_res = rt_val;
      end
      MEM_LWR: begin
        be_res = 4'b1111 >> (2'd3 - e);
        sd_res = rt_val;
      end
      default: ;
    endcase
    unique case (mem_op)
      MEM_LB:  ld_res = {{24{ld_byte[7]}}, ld_byte};
      MEM_LBU: ld_res = {24'b0, ld_byte};
      MEM_LH:  ld_res = {{16{ld_half[15]}}, ld_half};
      MEM_LHU: ld_res = {16'b0, ld_half};
      MEM_LW:  ld_res = readdata_eb;
      MEM_LWL: ld_res = (readdata_eb << lsh) | (rt_val & ((32'd1 << lsh) - 32'd1));
      MEM_LWR: ld_res = (readdata_eb >> rsh) | (rt_val & ~(32'hFFFF_FFFF >> rsh));
      default: ld_res = '0;
    endcase
  end

  always_comb begin
    out_valid_d  = in_valid;
    alu_out_d    = alu_out_q;
    byteenable_d = byteenable_q;
    store_data_d = store_data_q;
    load_word_d  = load_word_q;
    illegal_d    = illegal_q;
    overflow_d   = overflow_q;
    if (in_valid) begin
      alu_out_d    = alu_res;
      byteenable_d = be_res;
      store_data_d = sd_res;
      load_word_d  = ld_res;
      illegal_d    = dec_ill | misalign;
      overflow_d   = ovf_res;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q  <= 1'b0;
      alu_out_q    <= '0;
      byteenable_q <= '0;
      store_data_q <= '0;
      load_word_q  <= '0;
      illegal_q    <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      out_valid_q  <= out_valid_d;
      alu_out_q    <= alu_out_d;
      byteenable_q <= byteenable_d;
      store_data_q <= store_data_d;
      load_word_q  <= load_word_d;
      illegal_q    <= illegal_d;
      overflow_q   <= overflow_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign alu_out    = alu_out_q;
  assign byteenable = byteenable_q;
  assign store_data = store_data_q;
  assign load_word  = load_word_q;
  assign illegal    = illegal_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_mips_exec_datapath.sv
// Self-checking bench for mips_exec_datapath: byte-level reference model compared every cycle,
// plus hand-computed directed expectations. Honours OVERFLOW_TRAP_EN when defined.
module tb_mips_exec_datapath;

  logic        clk = 1'b0;
  logic        reset, in_valid;
  logic [5:0]  opcode, funct;
  logic [31:0] a, b, rt_val, readdata_eb;
  logic [1:0]  ld_lsb;
  logic        out_valid, illegal, overflow;
  logic [31:0] alu_out, store_data, load_word;
  logic [3:0]  byteenable;

  mips_exec_datapath dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .a(a), .b(b), .rt_val(rt_val), .readdata_eb(readdata_eb), .ld_lsb(ld_lsb),
    .out_valid(out_valid), .alu_out(alu_out), .byteenable(byteenable),
    .store_data(store_data), .load_word(load_word), .illegal(illegal), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] alu;
    logic [3:0]  be;
    logic [31:0] sd;
    logic [31:0] lw;
    logic        ill;
    logic        ovf;
  } res_t;

  int   vectors = 0;
  int   fails   = 0;
  bit   chk_en  = 1'b0;
  logic exp_v;
  res_t exp_r;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory access kinds for the model: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 LWL, 7 LWR, 8 SB, 9 SH, 10 SW
  function automatic res_t model(input logic [5:0] op, input logic [5:0] fn,
                                 input logic [31:0] ia, input logic [31:0] ib,
                                 input logic [31:0] rt, input logic [31:0] rd,
                                 input logic [1:0] l);
    res_t        r;
    logic [31:0] ea, w;
    logic [7:0]  bt [4];
    logic [7:0]  rb [4];
    logic [15:0] h;
    int unsigned e, li;
    int          kind;
    bit          trap, en;
    longint      s, sa, sb;
    r = '0; ea = ia + ib; e = ea[1:0]; li = l; kind = 0; trap = 0;
    sa = longint'($signed(ia)); sb = longint'($signed(ib)); s = 0;
    for (int k = 0; k < 4; k++) begin
      bt[k] = rd[31-8*k -: 8];
      rb[k] = rt[31-8*k -: 8];
    end
    if (op == 6'b000000) begin
      case (fn)
        6'b000000, 6'b000100: r.alu = ib << ia[4:0];
        6'b000010, 6'b000110: r.alu = ib >> ia[4:0];
        6'b000011, 6'b000111: r.alu = $signed(ib) >>> ia[4:0];
        6'b001000: r.alu = ia;
        6'b100000: begin r.alu = ea; s = sa + sb; trap = 1; end
        6'b100001: r.alu = ea;
        6'b100010: begin r.alu = ia - ib; s = sa - sb; trap = 1; end
        6'b100011: r.alu = ia - ib;
        6'b100100: r.alu = ia & ib;
        6'b100101: r.alu = ia | ib;
        6'b100110: r.alu = ia ^ ib;
        6'b100111: r.alu = ~(ia | ib);
        6'b101010: r.alu = (sa < sb) ? 32'd1 : 32'd0;
        6'b101011: r.alu = (ia < ib) ? 32'd1 : 32'd0;
        default:   r.ill = 1;
      endcase
    end else begin
      case (op)
        6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
        6'b000110, 6'b000111, 6'b001001: r.alu = ea;
        6'b001000: begin r.alu = ea; s = sa + sb; trap = 1; end
        6'b001010: r.alu = (sa < sb) ? 32'd1 : 32'd0;
        6'b001011: r.alu = (ia < ib) ? 32'd1 : 32'd0;
        6'b001100: r.alu = ia & ib;
        6'b001101: r.alu = ia | ib;
        6'b001110: r.alu = ia ^ ib;
        6'b001111: r.alu = ib[15:0] * 32'h10000;
        6'b100000: begin r.alu = ea; kind = 1;  end
        6'b100100: begin r.alu = ea; kind = 2;  end
        6'b100001: begin r.alu = ea; kind = 3;  end
        6'b100101: begin r.alu = ea; kind = 4;  end
        6'b100011: begin r.alu = ea; kind = 5;  end
        6'b100010: begin r.alu = ea; kind = 6;  end
        6'b100110: begin r.alu = ea; kind = 7;  end
        6'b101000: begin r.alu = ea; kind = 8;  end
        6'b101001: begin r.alu = ea; kind = 9;  end
        6'b101011: begin r.alu = ea; kind = 10; end
        default:   r.ill = 1;
      endcase
    end
    for (int k = 0; k < 4; k++) begin
      case (kind)
        1, 2, 8:  en = (k == e);
        3, 4, 9:  en = ((k / 2) == (e / 2));
        5, 10:    en = 1;
        6:        en = (k >= e);
        7:        en = (k <= e);
        default:  en = 0;
      endcase
      r.be[k] = en;
    end
    case (kind)
      1, 2, 8:        r.sd = {4{rt[7:0]}};
      3, 4, 9:        r.sd = {2{rt[15:0]}};
      5, 6, 7, 10:    r.sd = rt;
      default:        r.sd = 0;
    endcase
    if ((kind == 3 || kind == 4 || kind == 9) && (e % 2 == 1)) r.ill = 1;
    if ((kind == 5 || kind == 10) && e != 0) r.ill = 1;
    w = 0;
    case (kind)
      1: w = {{24{bt[li][7]}}, bt[li]};
      2: w = {24'b0, bt[li]};
      3, 4: begin
        h = {bt[2*(li/2)], bt[2*(li/2)+1]};
        w = (kind == 3) ? {{16{h[15]}}, h} : {16'b0, h};
      end
      5: w = rd;
      6: for (int j = 0; j < 4; j++) w[31-8*j -: 8] = (j + li <= 3) ? bt[j+li] : rb[j];
      7: for (int j = 0; j < 4; j++) w[31-8*j -: 8] = (j >= 3 - li) ? bt[j-(3-li)] : rb[j];
      default: w = 0;
    endcase
    r.lw = w;
`ifdef OVERFLOW_TRAP_EN
    if (trap && (s > 64'sd2147483647 || s < -64'sd2147483648)) r.ovf = 1;
`endif
    return r;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      exp_v <= 1'b0;
      exp_r <= '0;
    end else begin
      exp_v <= in_valid;
      if (in_valid) exp_r <= model(opcode, funct, a, b, rt_val, readdata_eb, ld_lsb);
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("m_out_valid",  {31'b0, out_valid}, {31'b0, exp_v});
      check("m_alu_out",    alu_out, exp_r.alu);
      check("m_byteenable", {28'b0, byteenable}, {28'b0, exp_r.be});
      check("m_store_data", store_data, exp_r.sd);
      check("m_load_word",  load_word, exp_r.lw);
      check("m_illegal",    {31'b0, illegal}, {31'b0, exp_r.ill});
      check("m_overflow",   {31'b0, overflow}, {31'b0, exp_r.ovf});
    end
  end

  task automatic apply(input logic [5:0] op, input logic [5:0] fn, input logic [31:0] ia,
                       input logic [31:0] ib, input logic [31:0] irt, input logic [31:0] ird,
                       input logic [1:0] il);
    @(negedge clk);
    opcode = op; funct = fn; a = ia; b = ib; rt_val = irt; readdata_eb = ird; ld_lsb = il;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  logic [5:0] op_tab [25] = '{6'b000001, 6'b000010, 6'b000011, 6'b000100, 6'b000101,
                              6'b000110, 6'b000111, 6'b001000, 6'b001001, 6'b001010,
                              6'b001011, 6'b001100, 6'b001101, 6'b001110, 6'b001111,
                              6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                              6'b100101, 6'b100110, 6'b101000, 6'b101001, 6'b101011};
  logic [5:0] fn_tab [17] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100, 6'b000110,
                              6'b000111, 6'b001000, 6'b100000, 6'b100001, 6'b100010,
                              6'b100011, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                              6'b101010, 6'b101011};

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0;
    a = '0; b = '0; rt_val = '0; readdata_eb = '0; ld_lsb = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    reset  = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_alu_out", alu_out, 32'd0);
    check("rst_byteenable", {28'b0, byteenable}, 32'd0);
    check("rst_store_data", store_data, 32'd0);
    check("rst_load_word", load_word, 32'd0);
    check("rst_illegal", {31'b0, illegal}, 32'd0);
    check("rst_overflow", {31'b0, overflow}, 32'd0);

    apply(6'b000000, 6'b100001, 32'd5, 32'hFFFF_FFFD, 32'd0, 32'd0, 2'd0);
    check("addu_alu", alu_out, 32'd2);
    check("addu_valid", {31'b0, out_valid}, 32'd1);
    apply(6'b000000, 6'b000011, 32'd4, 32'h8000_0000, 32'd0, 32'd0, 2'd0);
    check("sra", alu_out, 32'hF800_0000);
    apply(6'b000000, 6'b000010, 32'd4, 32'h8000_0000, 32'd0, 32'd0, 2'd0);
    check("srl", alu_out, 32'h0800_0000);
    apply(6'b000000, 6'b101010, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'd0);
    check("slt", alu_out, 32'd1);
    apply(6'b000000, 6'b101011, 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, 2'd0);
    check("sltu", alu_out, 32'd0);
    apply(6'b001111, 6'b000000, 32'd0, 32'h0000_1234, 32'd0, 32'd0, 2'd0);
    check("lui", alu_out, 32'h1234_0000);
    @(negedge clk);
    check("hold_valid", {31'b0, out_valid}, 32'd0);
    check("hold_alu", alu_out, 32'h1234_0000);

    apply(6'b100000, 6'b000000, 32'h100, 32'd3, 32'd0, 32'h1122_33F4, 2'd3);
    check("lb_alu", alu_out, 32'h103);
    check("lb_be", {28'b0, byteenable}, 32'b1000);
    check("lb_load", load_word, 32'hFFFF_FFF4);
    apply(6'b100100, 6'b000000, 32'h100, 32'd3, 32'd0, 32'h1122_33F4, 2'd3);
    check("lbu_load", load_word, 32'h0000_00F4);
    apply(6'b100010, 6'b000000, 32'h200, 32'd1, 32'h1122_3344, 32'hAABB_CCDD, 2'd1);
    check("lwl_load", load_word, 32'hBBCC_DD44);
    check("lwl_be", {28'b0, byteenable}, 32'b1110);
    apply(6'b100110, 6'b000000, 32'h200, 32'd1, 32'h1122_3344, 32'hAABB_CCDD, 2'd1);
    check("lwr_load", load_word, 32'h1122_AABB);
    check("lwr_be", {28'b0, byteenable}, 32'b0011);
    apply(6'b101001, 6'b000000, 32'h1000, 32'd2, 32'h0000_BEEF, 32'd0, 2'd0);
    check("sh_be", {28'b0, byteenable}, 32'b1100);
    check("sh_data", store_data, 32'hBEEF_BEEF);
    check("sh_illegal", {31'b0, illegal}, 32'd0);
    apply(6'b100011, 6'b000000, 32'h1000, 32'd1, 32'd0, 32'd0, 2'd0);
    check("lw_misalign", {31'b0, illegal}, 32'd1);
    apply(6'b111111, 6'b000000, 32'd9, 32'd9, 32'd0, 32'd0, 2'd0);
    check("bad_op_illegal", {31'b0, illegal}, 32'd1);
    check("bad_op_alu", alu_out, 32'd0);

    apply(6'b000000, 6'b100000, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 2'd0);
    check("add_wrap", alu_out, 32'h8000_0000);
`ifdef OVERFLOW_TRAP_EN
    check("add_ovf", {31'b0, overflow}, 32'd1);
`else
    check("add_ovf", {31'b0, overflow}, 32'd0);
`endif
    apply(6'b000000, 6'b100001, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 2'd0);
    check("addu_ovf", {31'b0, overflow}, 32'd0);

    // reset wins over a simultaneous valid operation
    @(negedge clk);
    opcode = 6'b001111; b = 32'h0000_5555; in_valid = 1'b1; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    check("rstpri_alu", alu_out, 32'd0);
    check("rstpri_valid", {31'b0, out_valid}, 32'd0);

    repeat (3000) begin
      int unsigned sel;
      @(negedge clk);
      reset    = ($urandom_range(0, 99) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      sel = $urandom_range(0, 9);
      if (sel < 4)      opcode = 6'b000000;
      else if (sel < 9) opcode = op_tab[$urandom_range(0, 24)];
      else              opcode = 6'($urandom);
      funct = ($urandom_range(0, 9) != 0) ? fn_tab[$urandom_range(0, 16)] : 6'($urandom);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'($signed(16'($urandom))) : $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h7FFF_FFF0 + 32'($urandom_range(0, 31));
      if ($urandom_range(0, 7) == 0) b = 32'h8000_0000 - 32'($urandom_range(0, 31));
      rt_val = $urandom; readdata_eb = $urandom; ld_lsb = 2'($urandom);
    end
    @(negedge clk);
    reset = 1'b0; in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
